inst_fetch: RTL

//   Instruction-fetch initiator for the single-port instruction ROM. Owns the fetch PC,

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_fifo.sv | 67 ++++++
 rtl/inst_fetch.sv | 69 ++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, defaults and the FIFO entry.
package inst_fetch_pkg;

    localparam int unsigned INST_W                = 32;
    localparam logic [31:0] RESET_PC_DEFAULT      = 32'h0000_0000;
    localparam int unsigned ADDR_WIDTH_IR_DEFAULT = 6;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
        logic              oob;
    } fetch_entry_t;

    // True when the byte address lies beyond a ROM of 2**aw words.
    function automatic logic is_oob(input logic [31:0] pc, input int unsigned aw);
        return (pc >> (aw + 2)) != '0;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst, oob} entries with flush; the head is taken
// from registered storage and holds its last shown value while empty.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         full,
    output logic         valid,
    output fetch_entry_t head
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    fetch_entry_t last_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign full  = (count == (PW+1)'(DEPTH));
    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (valid)
                last_q <= head;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the fetch PC, drives the ROM address, queues
// returned words and arbitrates redirects against decode back-pressure.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned ADDR_WIDTH_IR = ADDR_WIDTH_IR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       if_pc,
    output logic              if_oob
);

    logic [31:0]  fpc;
    logic         push;
    logic         pop;
    logic         full;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign imem_addr = fpc;
    assign pop       = if_valid && if_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a fetch.
    assign push      = !redirect_valid && (!full || pop);

    always_comb begin
        wr_entry      = '0;
        wr_entry.pc   = fpc;
        wr_entry.inst = imem_data;
        wr_entry.oob  = is_oob(fpc, ADDR_WIDTH_IR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fpc <= RESET_PC;
        else if (redirect_valid)
            fpc <= {redirect_pc[31:2], 2'b00};
        else if (push)
            fpc <= fpc + 32'd4;
    end

    inst_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .full     (full),
        .valid    (if_valid),
        .head     (head)
    );

    assign if_inst = head.inst;
    assign if_pc   = head.pc;
    assign if_oob  = head.oob;

endmodule
